id_stage_decoder: RTL and testbench

- Registered successor to the combinational instruction decoder. Decodes the IF/ID instruction, detects load-use hazards, and drives the ID/EX pipeline register.
- Holds an exception interlock between syscall/unknown detection and the CP0 acknowledge.
- Sits between the IF/ID latch and the EX stage of the 5-stage MIPS pipeline.
- Optionally decodes an extended instruction set.

---
 rtl/id_stage_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - registered MIPS ID stage: decode, load-use interlock, exception interlock, ID/EX register
//
// Purpose: decodes the IF/ID instruction, stalls on load-use hazards, blocks
// issue between a syscall/unknown instruction and the CP0 acknowledge, and
// drives the ID/EX pipeline register one cycle after decode.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   if_valid, if_inst, if_pc IF/ID latch contents
//   flush                    squash the instruction in ID
//   exc_ack                  CP0 has taken the pending exception
//   id_stall                 hold PC and IF/ID this cycle (combinational)
//   id_rs, id_rt             register-file read addresses (combinational)
//   id_beq/bne/j/jr          branch/jump decode, gated by stall/flush (combinational)
//   ex_*                     registered ID/EX controls, PC and register numbers

module id_stage_decoder #(
   parameter int EXT_OPS        = 1,
   parameter int LOAD_USE_STALL = 1,
   parameter int PC_W           = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [31:0]     if_inst,
   input  logic [PC_W-1:0] if_pc,
   input  logic            flush,
   input  logic            exc_ack,
   output logic            id_stall,
   output logic [4:0]      id_rs,
   output logic [4:0]      id_rt,
   output logic            id_beq,
   output logic            id_bne,
   output logic            id_j,
   output logic            id_jr,
   output logic            ex_valid,
   output logic [PC_W-1:0] ex_pc,
   output logic [3:0]      ex_aluop,
   output logic            ex_sign,
   output logic            ex_srcb,
   output logic            ex_ra,
   output logic            ex_shvar,
   output logic            ex_lui,
   output logic            ex_jal,
   output logic            ex_mem_rd,
   output logic            ex_mem_we,
   output logic            ex_mem_reg,
   output logic            ex_wb_we,
   output logic [4:0]      ex_wb_dreg,
   output logic            ex_alu_sign,
   output logic            ex_syscall,
   output logic            ex_unknown,
   output logic            ex_eret,
   output logic            ex_cp0_we,
   output logic            ex_mfc,
   output logic [4:0]      ex_cp0_dreg
);

   localparam bit EXT = (EXT_OPS != 0);
   localparam bit LUS = (LOAD_USE_STALL != 0);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   typedef struct packed {
      logic [3:0] aluop;
      logic       sign;
      logic       srcb;
      logic       ra;
      logic       shvar;
      logic       lui;
      logic       jal;
      logic       mem_rd;
      logic       mem_we;
      logic       mem_reg;
      logic       wb_we;
      logic [4:0] wb_dreg;
      logic       alu_sign;
      logic       syscall;
      logic       unknown;
      logic       eret;
      logic       cp0_we;
      logic       mfc;
      logic [4:0] cp0_dreg;
   } ctrl_t;

   typedef enum logic [0:0] {RUN = 1'b0, EXC_WAIT = 1'b1} state_t;

   state_t state, state_nx;
   ctrl_t  dec, ex_c;
   logic   issue;

   logic [5:0] op, fun;
   logic [4:0] rs, rt, rd;
   logic       unused_shamt;

   assign op  = if_inst[31:26];
   assign rs  = if_inst[25:21];
   assign rt  = if_inst[20:16];
   assign rd  = if_inst[15:11];
   assign fun = if_inst[5:0];
   assign unused_shamt = ^if_inst[10:6];

   assign id_rs = rs;
   assign id_rt = rt;

   // Decode flags used for hazard detection and branch outputs
   logic       r_hit, r_ovf, sh_imm, sh_var;
   logic [3:0] r_op;
   logic       i_hit, i_ovf, i_sext;
   logic [3:0] i_op;
   logic       d_nop, d_j, d_jal, d_beq, d_bne, d_jr, d_lui, d_sw, d_mtc0, d_mfc0;

   always_comb begin
      dec    = '0;
      r_hit  = 1'b0;
      r_ovf  = 1'b0;
      r_op   = ALU_AND;
      sh_imm = 1'b0;
      sh_var = 1'b0;
      i_hit  = 1'b0;
      i_ovf  = 1'b0;
      i_sext = 1'b0;
      i_op   = ALU_AND;
      d_nop  = 1'b0;
      d_j    = 1'b0;
      d_jal  = 1'b0;
      d_beq  = 1'b0;
      d_bne  = 1'b0;
      d_jr   = 1'b0;
      d_lui  = 1'b0;
      d_sw   = 1'b0;
      d_mtc0 = 1'b0;
      d_mfc0 = 1'b0;

      // An all-zero word would otherwise decode as sll $0; it must carry no controls.
      if (if_inst == 32'd0) begin
         d_nop = 1'b1;
      end else begin
         case (op)
            6'h00: begin
               case (fun)
                  6'h20: begin r_hit = 1'b1; r_op = ALU_ADD; r_ovf = 1'b1; end
                  6'h21: begin r_hit = 1'b1; r_op = ALU_ADD; end
                  6'h22: begin r_hit = 1'b1; r_op = ALU_SUB; r_ovf = 1'b1; end
                  6'h23: begin r_hit = 1'b1; r_op = ALU_SUB; end
                  6'h24: begin r_hit = 1'b1; r_op = ALU_AND; end
                  6'h25: begin r_hit = 1'b1; r_op = ALU_OR;  end
                  6'h26: begin r_hit = 1'b1; r_op = ALU_XOR; end
                  6'h27: begin r_hit = 1'b1; r_op = ALU_NOR; end
                  6'h2A: begin r_hit = 1'b1; r_op = ALU_SLT; end
                  6'h2B: begin
                     if (EXT) begin r_hit = 1'b1; r_op = ALU_SLTU; end
                     else dec.unknown = 1'b1;
                  end
                  6'h00: begin r_hit = 1'b1; r_op = ALU_SLL; sh_imm = 1'b1; end
                  6'h02: begin r_hit = 1'b1; r_op = ALU_SRL; sh_imm = 1'b1; end
                  6'h03: begin
                     if (EXT) begin r_hit = 1'b1; r_op = ALU_SRA; sh_imm = 1'b1; end
                     else dec.unknown = 1'b1;
                  end
                  6'h04: begin
                     if (EXT) begin r_hit = 1'b1; r_op = ALU_SLL; sh_var = 1'b1; end
                     else dec.unknown = 1'b1;
                  end
                  6'h06: begin
                     if (EXT) begin r_hit = 1'b1; r_op = ALU_SRL; sh_var = 1'b1; end
                     else dec.unknown = 1'b1;
                  end
                  6'h07: begin
                     if (EXT) begin r_hit = 1'b1; r_op = ALU_SRA; sh_var = 1'b1; end
                     else dec.unknown = 1'b1;
                  end
                  6'h08: d_jr = 1'b1;
                  6'h09: begin
                     // jalr: register jump that links into $31
                     d_jr         = 1'b1;
                     dec.jal      = 1'b1;
                     dec.wb_we    = 1'b1;
                     dec.wb_dreg  = 5'd31;
                     dec.mem_reg  = 1'b1;
                  end
                  6'h0C: dec.syscall = 1'b1;
                  default: dec.unknown = 1'b1;
               endcase
            end
            6'h08: begin i_hit = 1'b1; i_op = ALU_ADD; i_sext = 1'b1; i_ovf = 1'b1; end
            6'h09: begin i_hit = 1'b1; i_op = ALU_ADD; i_sext = 1'b1; end
            6'h0A: begin i_hit = 1'b1; i_op = ALU_SLT; i_sext = 1'b1; end
            6'h0B: begin
               if (EXT) begin i_hit = 1'b1; i_op = ALU_SLTU; i_sext = 1'b1; end
               else dec.unknown = 1'b1;
            end
            6'h0C: begin i_hit = 1'b1; i_op = ALU_AND; end
            6'h0D: begin i_hit = 1'b1; i_op = ALU_OR;  end
            6'h0E: begin i_hit = 1'b1; i_op = ALU_XOR; end
            6'h0F: begin
               d_lui       = 1'b1;
               dec.lui     = 1'b1;
               dec.srcb    = 1'b1;
               dec.wb_we   = 1'b1;
               dec.wb_dreg = rt;
               dec.mem_reg = 1'b1;
            end
            6'h23: begin
               dec.aluop   = ALU_ADD;
               dec.sign    = 1'b1;
               dec.srcb    = 1'b1;
               dec.mem_rd  = 1'b1;
               dec.wb_we   = 1'b1;
               dec.wb_dreg = rt;
            end
            6'h2B: begin
               d_sw       = 1'b1;
               dec.aluop  = ALU_ADD;
               dec.sign   = 1'b1;
               dec.srcb   = 1'b1;
               dec.mem_we = 1'b1;
            end
            6'h04: begin d_beq = 1'b1; dec.sign = 1'b1; end
            6'h05: begin d_bne = 1'b1; dec.sign = 1'b1; end
            6'h02: d_j = 1'b1;
            6'h03: begin
               d_jal       = 1'b1;
               dec.jal     = 1'b1;
               dec.wb_we   = 1'b1;
               dec.wb_dreg = 5'd31;
               dec.mem_reg = 1'b1;
            end
            6'h10: begin
               if (rs == 5'h00) begin
                  d_mfc0       = 1'b1;
                  dec.mfc      = 1'b1;
                  dec.wb_we    = 1'b1;
                  dec.wb_dreg  = rt;
                  dec.cp0_dreg = rd;
               end else if (rs == 5'h04) begin
                  d_mtc0       = 1'b1;
                  dec.cp0_we   = 1'b1;
                  dec.cp0_dreg = rd;
               end else if (rs == 5'h10 && fun == 6'h18) begin
                  dec.eret = 1'b1;
               end else begin
                  dec.unknown = 1'b1;
               end
            end
            default: dec.unknown = 1'b1;
         endcase

         if (r_hit) begin
            dec.aluop    = r_op;
            dec.alu_sign = r_ovf;
            dec.wb_we    = 1'b1;
            dec.wb_dreg  = rd;
            dec.mem_reg  = 1'b1;
            dec.ra       = sh_imm;
            dec.srcb     = sh_imm;
            dec.shvar    = sh_var;
         end
         if (i_hit) begin
            dec.aluop    = i_op;
            dec.alu_sign = i_ovf;
            dec.sign     = i_sext;
            dec.srcb     = 1'b1;
            dec.wb_we    = 1'b1;
            dec.wb_dreg  = rt;
            dec.mem_reg  = 1'b1;
         end
      end
   end

   logic uses_rs, uses_rt, load_use;

   assign uses_rs = ~(d_nop | d_j | d_jal | d_lui | sh_imm | dec.syscall |
                      dec.eret | d_mfc0 | d_mtc0);
   assign uses_rt = r_hit | d_beq | d_bne | d_sw | d_mtc0;

   assign load_use = LUS & if_valid & ex_valid & ex_c.mem_rd & (ex_c.wb_dreg != 5'd0) &
                     ((uses_rs & (rs == ex_c.wb_dreg)) | (uses_rt & (rt == ex_c.wb_dreg)));

   // flush outranks both the exception block and the load-use stall
   assign id_stall = ~flush & ((state == EXC_WAIT) | load_use);

   logic br_ok;
   assign br_ok  = if_valid & ~id_stall & ~flush;
   assign id_beq = br_ok & d_beq;
   assign id_bne = br_ok & d_bne;
   assign id_j   = br_ok & (d_j | d_jal);
   assign id_jr  = br_ok & d_jr;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      case (state)
         RUN: begin
            if (!flush && !load_use && if_valid) begin
               issue = 1'b1;
               if (dec.syscall || dec.unknown) state_nx = EXC_WAIT;
            end
         end
         EXC_WAIT: begin
            if (exc_ack) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         ex_valid <= 1'b0;
         ex_pc    <= '0;
         ex_c     <= '0;
      end else begin
         state    <= state_nx;
         ex_valid <= issue;
         ex_pc    <= issue ? if_pc : '0;
         ex_c     <= issue ? dec : '0;
      end
   end

   assign ex_aluop    = ex_c.aluop;
   assign ex_sign     = ex_c.sign;
   assign ex_srcb     = ex_c.srcb;
   assign ex_ra       = ex_c.ra;
   assign ex_shvar    = ex_c.shvar;
   assign ex_lui      = ex_c.lui;
   assign ex_jal      = ex_c.jal;
   assign ex_mem_rd   = ex_c.mem_rd;
   assign ex_mem_we   = ex_c.mem_we;
   assign ex_mem_reg  = ex_c.mem_reg;
   assign ex_wb_we    = ex_c.wb_we;
   assign ex_wb_dreg  = ex_c.wb_dreg;
   assign ex_alu_sign = ex_c.alu_sign;
   assign ex_syscall  = ex_c.syscall;
   assign ex_unknown  = ex_c.unknown;
   assign ex_eret     = ex_c.eret;
   assign ex_cp0_we   = ex_c.cp0_we;
   assign ex_mfc      = ex_c.mfc;
   assign ex_cp0_dreg = ex_c.cp0_dreg;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb/tb_id_stage_decoder.sv - directed self-checking bench for id_stage_decoder
`timescale 1ns/1ps

module tb_id_stage_decoder;

   localparam logic [31:0] I_LW   = 32'h8FA80000;
   localparam logic [31:0] I_ADD  = 32'h01084820;
   localparam logic [31:0] I_SLTU = 32'h0085102B;
   localparam logic [31:0] I_SYS  = 32'h0000000C;
   localparam logic [31:0] I_ERET = 32'h42000018;
   localparam logic [31:0] I_SRA  = 32'h00041883;
   localparam logic [31:0] I_SLLV = 32'h00A41804;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_BEQ  = 32'h11000003;

   logic        clk = 1'b0;
   logic        rst_n, if_valid, flush, exc_ack;
   logic [31:0] if_inst, if_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // main DUT (defaults)
   logic        id_stall, id_beq, id_bne, id_j, id_jr;
   logic [4:0]  id_rs, id_rt, ex_wb_dreg, ex_cp0_dreg;
   logic        ex_valid, ex_sign, ex_srcb, ex_ra, ex_shvar, ex_lui, ex_jal;
   logic        ex_mem_rd, ex_mem_we, ex_mem_reg, ex_wb_we, ex_alu_sign;
   logic        ex_syscall, ex_unknown, ex_eret, ex_cp0_we, ex_mfc;
   logic [31:0] ex_pc;
   logic [3:0]  ex_aluop;

   // LOAD_USE_STALL=0 DUT
   logic        n_stall, n_beq, n_bne, n_j, n_jr;
   logic [4:0]  n_rs, n_rt, n_wb_dreg, n_cp0_dreg;
   logic        n_valid, n_sign, n_srcb, n_ra, n_shvar, n_lui, n_jal;
   logic        n_mem_rd, n_mem_we, n_mem_reg, n_wb_we, n_alu_sign;
   logic        n_syscall, n_unknown, n_eret, n_cp0_we, n_mfc;
   logic [31:0] n_pc;
   logic [3:0]  n_aluop;

   // EXT_OPS=0 DUT
   logic        x_stall, x_beq, x_bne, x_j, x_jr;
   logic [4:0]  x_rs, x_rt, x_wb_dreg, x_cp0_dreg;
   logic        x_valid, x_sign, x_srcb, x_ra, x_shvar, x_lui, x_jal;
   logic        x_mem_rd, x_mem_we, x_mem_reg, x_wb_we, x_alu_sign;
   logic        x_syscall, x_unknown, x_eret, x_cp0_we, x_mfc;
   logic [31:0] x_pc;
   logic [3:0]  x_aluop;

   id_stage_decoder u_dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .flush(flush), .exc_ack(exc_ack), .id_stall(id_stall), .id_rs(id_rs), .id_rt(id_rt),
      .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j), .id_jr(id_jr), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_sign(ex_sign), .ex_srcb(ex_srcb), .ex_ra(ex_ra),
      .ex_shvar(ex_shvar), .ex_lui(ex_lui), .ex_jal(ex_jal), .ex_mem_rd(ex_mem_rd),
      .ex_mem_we(ex_mem_we), .ex_mem_reg(ex_mem_reg), .ex_wb_we(ex_wb_we),
      .ex_wb_dreg(ex_wb_dreg), .ex_alu_sign(ex_alu_sign), .ex_syscall(ex_syscall),
      .ex_unknown(ex_unknown), .ex_eret(ex_eret), .ex_cp0_we(ex_cp0_we), .ex_mfc(ex_mfc),
      .ex_cp0_dreg(ex_cp0_dreg)
   );

   id_stage_decoder #(.LOAD_USE_STALL(0)) u_nols (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .flush(flush), .exc_ack(exc_ack), .id_stall(n_stall), .id_rs(n_rs), .id_rt(n_rt),
      .id_beq(n_beq), .id_bne(n_bne), .id_j(n_j), .id_jr(n_jr), .ex_valid(n_valid),
      .ex_pc(n_pc), .ex_aluop(n_aluop), .ex_sign(n_sign), .ex_srcb(n_srcb), .ex_ra(n_ra),
      .ex_shvar(n_shvar), .ex_lui(n_lui), .ex_jal(n_jal), .ex_mem_rd(n_mem_rd),
      .ex_mem_we(n_mem_we), .ex_mem_reg(n_mem_reg), .ex_wb_we(n_wb_we),
      .ex_wb_dreg(n_wb_dreg), .ex_alu_sign(n_alu_sign), .ex_syscall(n_syscall),
      .ex_unknown(n_unknown), .ex_eret(n_eret), .ex_cp0_we(n_cp0_we), .ex_mfc(n_mfc),
      .ex_cp0_dreg(n_cp0_dreg)
   );

   id_stage_decoder #(.EXT_OPS(0)) u_noext (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .flush(flush), .exc_ack(exc_ack), .id_stall(x_stall), .id_rs(x_rs), .id_rt(x_rt),
      .id_beq(x_beq), .id_bne(x_bne), .id_j(x_j), .id_jr(x_jr), .ex_valid(x_valid),
      .ex_pc(x_pc), .ex_aluop(x_aluop), .ex_sign(x_sign), .ex_srcb(x_srcb), .ex_ra(x_ra),
      .ex_shvar(x_shvar), .ex_lui(x_lui), .ex_jal(x_jal), .ex_mem_rd(x_mem_rd),
      .ex_mem_we(x_mem_we), .ex_mem_reg(x_mem_reg), .ex_wb_we(x_wb_we),
      .ex_wb_dreg(x_wb_dreg), .ex_alu_sign(x_alu_sign), .ex_syscall(x_syscall),
      .ex_unknown(x_unknown), .ex_eret(x_eret), .ex_cp0_we(x_cp0_we), .ex_mfc(x_mfc),
      .ex_cp0_dreg(x_cp0_dreg)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
      flush = 1'b0; exc_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // drive IF/ID at the falling edge, then settle
   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      @(negedge clk);
      if_valid = v; if_inst = inst; if_pc = pc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b1, I_ADD, 32'h0000_0040);
      tick();
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0d exp 1", ex_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0d exp 0", ex_valid); end
      checks++; if (ex_aluop !== 4'b0000) begin errors++; $display("FAIL rst_async_aluop got %b exp 0000", ex_aluop); end
      checks++; if (ex_wb_we !== 1'b0 || ex_wb_dreg !== 5'd0 || ex_mem_reg !== 1'b0) begin errors++; $display("FAIL rst_async_wb got we=%0d dreg=%0d mreg=%0d exp 0/0/0", ex_wb_we, ex_wb_dreg, ex_mem_reg); end
      checks++; if (ex_pc !== 32'd0 || ex_alu_sign !== 1'b0) begin errors++; $display("FAIL rst_async_pc got pc=%h as=%0d exp 0/0", ex_pc, ex_alu_sign); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, I_ADD, 32'h0000_0044);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_run_stall got %0d exp 0", id_stall); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h44) begin errors++; $display("FAIL rst_run_issue got v=%0d pc=%h exp 1/44", ex_valid, ex_pc); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, I_LW, 32'h0000_0100);
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_mem_rd !== 1'b1 || ex_mem_reg !== 1'b0) begin errors++; $display("FAIL lu_lw got v=%0d rd=%0d mreg=%0d exp 1/1/0", ex_valid, ex_mem_rd, ex_mem_reg); end
      checks++; if (ex_wb_dreg !== 5'd8 || ex_wb_we !== 1'b1 || ex_aluop !== 4'b0010) begin errors++; $display("FAIL lu_lw_wb got dreg=%0d we=%0d op=%b exp 8/1/0010", ex_wb_dreg, ex_wb_we, ex_aluop); end
      drive(1'b1, I_ADD, 32'h0000_0104);
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", id_stall); end
      checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL lu_nols_stall got %0d exp 0", n_stall); end
      checks++; if (id_rs !== 5'd8 || id_rt !== 5'd8) begin errors++; $display("FAIL lu_rs_rt got %0d/%0d exp 8/8", id_rs, id_rt); end
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_wb_we !== 1'b0 || ex_pc !== 32'd0) begin errors++; $display("FAIL lu_bubble got v=%0d we=%0d pc=%h exp 0/0/0", ex_valid, ex_wb_we, ex_pc); end
      checks++; if (n_valid !== 1'b1 || n_aluop !== 4'b0010 || n_wb_dreg !== 5'd9) begin errors++; $display("FAIL lu_nols_add got v=%0d op=%b dreg=%0d exp 1/0010/9", n_valid, n_aluop, n_wb_dreg); end
      drive(1'b1, I_ADD, 32'h0000_0104);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0d exp 0", id_stall); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_aluop !== 4'b0010 || ex_wb_dreg !== 5'd9) begin errors++; $display("FAIL lu_add got v=%0d op=%b dreg=%0d exp 1/0010/9", ex_valid, ex_aluop, ex_wb_dreg); end
      checks++; if (ex_alu_sign !== 1'b1 || ex_mem_reg !== 1'b1 || ex_pc !== 32'h104) begin errors++; $display("FAIL lu_add_ctl got as=%0d mreg=%0d pc=%h exp 1/1/104", ex_alu_sign, ex_mem_reg, ex_pc); end
   endtask

   task automatic test_ext_ops();
      do_reset();
      drive(1'b1, I_SLTU, 32'h0000_0200);
      tick();
      checks++; if (ex_aluop !== 4'b1001 || ex_wb_dreg !== 5'd2 || ex_unknown !== 1'b0) begin errors++; $display("FAIL ext_sltu got op=%b dreg=%0d unk=%0d exp 1001/2/0", ex_aluop, ex_wb_dreg, ex_unknown); end
      checks++; if (x_valid !== 1'b1 || x_unknown !== 1'b1 || x_wb_we !== 1'b0) begin errors++; $display("FAIL ext_off_unknown got v=%0d unk=%0d we=%0d exp 1/1/0", x_valid, x_unknown, x_wb_we); end
      drive(1'b1, 32'd0, 32'h0000_0204);
      checks++; if (x_stall !== 1'b1) begin errors++; $display("FAIL ext_off_excwait got %0d exp 1", x_stall); end
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ext_on_nostall got %0d exp 0", id_stall); end
      tick();
      checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL ext_off_bubble got %0d exp 0", x_valid); end
      checks++; if (ex_valid !== 1'b1 || ex_wb_we !== 1'b0 || ex_aluop !== 4'b0000 || ex_ra !== 1'b0 || ex_srcb !== 1'b0 || ex_mem_reg !== 1'b0) begin errors++; $display("FAIL nop_ctl got v=%0d we=%0d op=%b ra=%0d srcb=%0d mreg=%0d exp 1/0/0000/0/0/0", ex_valid, ex_wb_we, ex_aluop, ex_ra, ex_srcb, ex_mem_reg); end
      @(negedge clk);
      exc_ack = 1'b1; if_valid = 1'b0;
      tick();
      @(negedge clk);
      exc_ack = 1'b0;
      #1;
      checks++; if (x_stall !== 1'b0) begin errors++; $display("FAIL ext_off_ack got %0d exp 0", x_stall); end
   endtask

   task automatic test_shifts_jal();
      do_reset();
      drive(1'b1, I_SRA, 32'h0000_0300);
      tick();
      checks++; if (ex_aluop !== 4'b1010 || ex_ra !== 1'b1 || ex_srcb !== 1'b1 || ex_shvar !== 1'b0 || ex_wb_dreg !== 5'd3) begin errors++; $display("FAIL sra got op=%b ra=%0d srcb=%0d shv=%0d dreg=%0d exp 1010/1/1/0/3", ex_aluop, ex_ra, ex_srcb, ex_shvar, ex_wb_dreg); end
      drive(1'b1, I_SLLV, 32'h0000_0304);
      tick();
      checks++; if (ex_aluop !== 4'b1000 || ex_ra !== 1'b0 || ex_srcb !== 1'b0 || ex_shvar !== 1'b1 || ex_wb_dreg !== 5'd3) begin errors++; $display("FAIL sllv got op=%b ra=%0d srcb=%0d shv=%0d dreg=%0d exp 1000/0/0/1/3", ex_aluop, ex_ra, ex_srcb, ex_shvar, ex_wb_dreg); end
      drive(1'b1, I_JAL, 32'h0000_0308);
      checks++; if (id_j !== 1'b1 || id_jr !== 1'b0) begin errors++; $display("FAIL jal_id_j got j=%0d jr=%0d exp 1/0", id_j, id_jr); end
      tick();
      checks++; if (ex_jal !== 1'b1 || ex_wb_dreg !== 5'd31 || ex_mem_reg !== 1'b1 || ex_wb_we !== 1'b1) begin errors++; $display("FAIL jal_ex got jal=%0d dreg=%0d mreg=%0d we=%0d exp 1/31/1/1", ex_jal, ex_wb_dreg, ex_mem_reg, ex_wb_we); end
   endtask

   task automatic test_exception();
      do_reset();
      drive(1'b1, I_SYS, 32'h0000_0400);
      tick();
      checks++; if (ex_syscall !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL exc_sys got sys=%0d v=%0d exp 1/1", ex_syscall, ex_valid); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, I_ADD, 32'h0000_0404 + 32'(4 * k));
         if (k == 1) begin
            flush = 1'b1;
            #1;
            checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL exc_flush_stall got %0d exp 0", id_stall); end
         end else begin
            checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL exc_block_stall_%0d got %0d exp 1", k, id_stall); end
         end
         tick();
         flush = 1'b0;
         checks++; if (ex_valid !== 1'b0 || ex_syscall !== 1'b0) begin errors++; $display("FAIL exc_bubble_%0d got v=%0d sys=%0d exp 0/0", k, ex_valid, ex_syscall); end
      end
      @(negedge clk);
      exc_ack = 1'b1; if_valid = 1'b0;
      tick();
      @(negedge clk);
      exc_ack = 1'b0;
      drive(1'b1, I_ERET, 32'h0000_0410);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL exc_ack_release got %0d exp 0", id_stall); end
      tick();
      checks++; if (ex_eret !== 1'b1 || ex_valid !== 1'b1 || ex_wb_we !== 1'b0) begin errors++; $display("FAIL eret got eret=%0d v=%0d we=%0d exp 1/1/0", ex_eret, ex_valid, ex_wb_we); end
      drive(1'b1, I_ADD, 32'h0000_0414);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL eret_run got %0d exp 0", id_stall); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, I_LW, 32'h0000_0500);
      tick();
      drive(1'b1, I_BEQ, 32'h0000_0504);
      checks++; if (id_stall !== 1'b1 || id_beq !== 1'b0) begin errors++; $display("FAIL fl_hazard got stall=%0d beq=%0d exp 1/0", id_stall, id_beq); end
      flush = 1'b1;
      #1;
      checks++; if (id_stall !== 1'b0 || id_beq !== 1'b0) begin errors++; $display("FAIL fl_over_stall got stall=%0d beq=%0d exp 0/0", id_stall, id_beq); end
      tick();
      flush = 1'b0;
      checks++; if (ex_valid !== 1'b0 || ex_sign !== 1'b0) begin errors++; $display("FAIL fl_bubble got v=%0d sign=%0d exp 0/0", ex_valid, ex_sign); end
      drive(1'b1, I_BEQ, 32'h0000_0504);
      checks++; if (id_beq !== 1'b1 || id_stall !== 1'b0) begin errors++; $display("FAIL fl_beq_free got beq=%0d stall=%0d exp 1/0", id_beq, id_stall); end
      drive(1'b0, I_ADD, 32'h0000_0508);
      tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_invalid got %0d exp 0", ex_valid); end
   endtask

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
      flush = 1'b0; exc_ack = 1'b0;
      #1;
      checks++; if (ex_valid !== 1'b0 || ex_aluop !== 4'b0000 || id_stall !== 1'b0) begin errors++; $display("FAIL reset_state got v=%0d op=%b stall=%0d exp 0/0000/0", ex_valid, ex_aluop, id_stall); end
      test_reset();
      test_load_use();
      test_ext_ops();
      test_shifts_jal();
      test_exception();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
